interval_sequencer: RTL and testbench

Initiator side of the timer enable/done interface. On a start request, runs an attached LIMIT-cycle timer a programmable number of consecutive intervals:
- holds `timer_en` high until `timer_done`;
- drops `timer_en` to re-arm the timer;
- pulses `tick` per completed interval and `finished` after the last one.

A watchdog flags a timer that never reports done. The block sits between module-level control logic and one timer instance.

---
 rtl/interval_seq_pkg.sv | 11 +
 rtl/interval_sequencer_if.sv | 11 +
 rtl/interval_sequencer.sv | 112 +++++++++++
 tb/tb_interval_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_seq_pkg.sv
// Shared types for the interval sequencer: the FSM state encoding used by the
// design and by anything that observes its debug state output.
package interval_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/interval_sequencer_if.sv
// Timer enable/done link between the sequencer (master) and one timer (slave).
// Handshake: the master holds timer_en high to let the timer count; the timer
// holds timer_done high while its count sits at its limit; dropping timer_en
// clears the timer, and done is only meaningful while timer_en is high.
interface interval_sequencer_if;
  logic timer_en;
  logic timer_done;

  modport master (output timer_en, input timer_done);
  modport slave  (input timer_en, output timer_done);
endinterface

// File: rtl/interval_sequencer.sv
// Runs an attached timer for a programmable number of back-to-back intervals,
// re-arming it between intervals and flagging a timer that never reports done.
module interval_sequencer
  import interval_seq_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int GAP      = 1,
  parameter int MAX_WAIT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_intervals,
  input  logic                    abort,
  interval_sequencer_if.master    tmr,
  output logic                    busy,
  output logic                    tick,
  output logic                    finished,
  output logic [CNT_W-1:0]        intervals_done,
  output logic                    err,
  output state_t                  state_dbg
);

  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    n_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    done_inc;
  logic                last_interval;
  logic                accept;
  logic                done_ev;
  logic                expire_ev;
  logic                timer_en_c;

  // Event decode: abort outranks done, and done outranks watchdog expiry.
  assign accept        = (state_q == ST_IDLE) && start;
  assign done_inc      = intervals_done + CNT_W'(1);
  assign last_interval = (done_inc == n_q);
  assign done_ev       = (state_q == ST_RUN) && !abort && tmr.timer_done;
  assign expire_ev     = (state_q == ST_RUN) && !abort && !tmr.timer_done &&
                         (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && (n_intervals != '0)) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                 state_d = ST_IDLE;
        else if (tmr.timer_done)   state_d = last_interval ? ST_IDLE : ST_GAP;
        else if (expire_ev)        state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (abort)                 state_d = ST_IDLE;
        else if (gap_cnt == '0)    state_d = ST_RUN;
      end
      default:                     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_en_c = (state_q == ST_RUN);
    busy       = (state_q != ST_IDLE);
    state_dbg  = state_q;
  end

  assign tmr.timer_en = timer_en_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q            <= '0;
      intervals_done <= '0;
      tick           <= 1'b0;
      finished       <= 1'b0;
      err            <= 1'b0;
      gap_cnt        <= '0;
      wait_cnt       <= '0;
    end else begin
      tick     <= done_ev;
      finished <= (accept && (n_intervals == '0)) || (done_ev && last_interval);

      if (accept) begin
        n_q            <= n_intervals;
        intervals_done <= '0;
        err            <= 1'b0;
      end else begin
        if (done_ev)   intervals_done <= done_inc;
        if (expire_ev) err            <= 1'b1;
      end

      // Wait counter restarts on every entry into RUN, whether from IDLE or GAP.
      if ((state_d == ST_RUN) && (state_q != ST_RUN))
        wait_cnt <= '0;
      else if ((state_q == ST_RUN) && !tmr.timer_done)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if (done_ev)
        gap_cnt <= GAP_W'(GAP - 1);
      else if ((state_q == ST_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_interval_sequencer.sv
// Bench for interval_sequencer: a behavioural LIMIT-cycle timer as responder,
// a per-cycle arithmetic prediction of the output timeline, table and random runs.
module tb_interval_sequencer;
  import interval_seq_pkg::*;

  localparam int CNT_W    = 8;
  localparam int GAP_P    = 1;
  localparam int MAX_WAIT = 8;
  localparam int L        = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic [CNT_W-1:0] n_intervals = '0;
  logic             abort = 1'b0;
  logic             busy, tick, finished, err;
  logic [CNT_W-1:0] intervals_done;
  state_t           state_dbg;

  logic wd_mode  = 1'b0;
  logic force_hi = 1'b0;
  logic model_done;
  int   tcnt;

  interval_sequencer_if tmr_if ();

  interval_sequencer #(.CNT_W(CNT_W), .GAP(GAP_P), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .n_intervals    (n_intervals),
    .abort          (abort),
    .tmr            (tmr_if.master),
    .busy           (busy),
    .tick           (tick),
    .finished       (finished),
    .intervals_done (intervals_done),
    .err            (err),
    .state_dbg      (state_dbg)
  );

  // Timer responder: counts up to L while enabled, cleared when enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tcnt <= 0;
    else if (!tmr_if.timer_en) tcnt <= 0;
    else if (tcnt < L)         tcnt <= tcnt + 1;
  end
  assign model_done = (tcnt == L);
  assign tmr_if.timer_done = wd_mode ? 1'b0 : (model_done | force_hi);

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected outputs at cycle c, counted from the cycle in which start is driven.
  function automatic void predict(input int c, input int n, input int a,
                                  output logic e_en, output logic e_busy,
                                  output logic e_tick, output logic e_fin,
                                  output int e_idone);
    int p, stop, tc;
    bit aborted, ok;
    p = L + 1 + GAP_P;
    stop = (n == 0) ? 1 : 2 + (n - 1) * p + L;
    aborted = 1'b0;
    if (n > 0 && a >= 1 && a < stop) begin
      stop = a + 1;
      aborted = 1'b1;
    end
    e_busy = (n > 0) && (c >= 1) && (c < stop);
    e_en   = e_busy && (((c - 1) % p) <= L);
    e_tick = 1'b0;
    e_idone = 0;
    for (int k = 0; k < n; k++) begin
      tc = 2 + L + k * p;
      ok = aborted ? (tc < stop) : (tc <= stop);
      if (ok && tc <= c) e_idone++;
      if (ok && tc == c) e_tick = 1'b1;
    end
    e_fin = !aborted && (c == stop);
  endfunction

  // Driver: called at a negedge; drives one sequence and checks every cycle.
  task automatic run_seq(input int n, input int a, input int frc, input int xs_n,
                         output int obs_ticks, output int obs_fin, output int obs_idone);
    logic e_en, e_busy, e_tick, e_fin;
    int e_idone, last;
    last = ((n == 0) ? 1 : 2 + (n - 1) * (L + 1 + GAP_P) + L) + 3;
    obs_ticks = 0;
    obs_fin = 0;
    for (int c = 0; c <= last; c++) begin
      if (c >= 1) begin
        predict(c, n, a, e_en, e_busy, e_tick, e_fin, e_idone);
        check("timer_en", 32'(tmr_if.timer_en), 32'(e_en));
        check("busy", 32'(busy), 32'(e_busy));
        check("tick", 32'(tick), 32'(e_tick));
        check("finished", 32'(finished), 32'(e_fin));
        check("intervals_done", 32'(intervals_done), 32'(e_idone));
        check("err", 32'(err), 32'd0);
        obs_ticks += int'(tick);
        obs_fin += int'(finished);
      end else begin
        e_busy = 1'b0;
      end
      start = 1'b0;
      if (c == 0) begin
        start = 1'b1;
        n_intervals = CNT_W'(n);
      end else if (xs_n >= 0 && e_busy && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        n_intervals = CNT_W'(xs_n);
      end
      abort = (c == a);
      force_hi = (c == frc);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    force_hi = 1'b0;
    obs_idone = int'(intervals_done);
  endtask

  typedef struct {
    int n;
    int abort_rel;
    int force_rel;
    int xs_n;
    int exp_ticks;
    int exp_idone;
    int exp_fin;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int ot, of, oi;
    vecs[0] = '{3,   -1, -1, -1, 3,   3,   1};  // normal run
    vecs[1] = '{0,   -1, -1, -1, 0,   0,   1};  // zero request
    vecs[2] = '{1,   -1, -1, -1, 1,   1,   1};
    vecs[3] = '{5,    8, -1, -1, 1,   1,   0};  // abort in second RUN
    vecs[4] = '{5,   11, -1, -1, 1,   1,   0};  // abort with timer_done
    vecs[5] = '{2,    6, -1, -1, 1,   1,   0};  // abort in GAP
    vecs[6] = '{2,   -1,  6,  9, 2,   2,   1};  // done forced in GAP, starts while busy
    vecs[7] = '{255, -1, -1, -1, 255, 255, 1};  // largest count

    // reset state
    repeat (3) @(negedge clk);
    check("rst timer_en", 32'(tmr_if.timer_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tick", 32'(tick), 32'd0);
    check("rst finished", 32'(finished), 32'd0);
    check("rst intervals_done", 32'(intervals_done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_seq(vecs[i].n, vecs[i].abort_rel, vecs[i].force_rel, vecs[i].xs_n, ot, of, oi);
      exp_q.push_back(32'(vecs[i].exp_ticks));
      exp_q.push_back(32'(vecs[i].exp_fin));
      exp_q.push_back(32'(vecs[i].exp_idone));
      check("vec ticks", 32'(ot), exp_q.pop_front());
      check("vec finished", 32'(of), exp_q.pop_front());
      check("vec intervals_done", 32'(oi), exp_q.pop_front());
    end

    // randomized sequences with random aborts and ignored starts
    for (int r = 0; r < 25; r++) begin
      int n, a, xs;
      n  = $urandom_range(0, 6);
      a  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n * (L + 1 + GAP_P) + 2)) : -1;
      xs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1;
      run_seq(n, a, -1, xs, ot, of, oi);
    end

    // watchdog: timer never reports done
    wd_mode = 1'b1;
    start = 1'b1;
    n_intervals = CNT_W'(2);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      check("wd timer_en", 32'(tmr_if.timer_en), 32'(c <= MAX_WAIT));
      check("wd busy", 32'(busy), 32'(c <= MAX_WAIT));
      check("wd err", 32'(err), 32'(c > MAX_WAIT));
      check("wd tick", 32'(tick), 32'd0);
      check("wd finished", 32'(finished), 32'd0);
      @(negedge clk);
    end
    check("wd intervals_done", 32'(intervals_done), 32'd0);
    wd_mode = 1'b0;
    @(negedge clk);
    // next accepted start clears err (checked cycle by cycle inside run_seq)
    run_seq(0, -1, -1, -1, ot, of, oi);
    check("err clear finished", 32'(of), 32'd1);

    // asynchronous reset in the middle of RUN
    start = 1'b1;
    n_intervals = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset timer_en", 32'(tmr_if.timer_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async timer_en", 32'(tmr_if.timer_en), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async intervals_done", 32'(intervals_done), 32'd0);
    check("async err", 32'(err), 32'd0);
    check("async state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(2, -1, -1, -1, ot, of, oi);
    check("post-reset ticks", 32'(ot), 32'd2);
    check("post-reset intervals_done", 32'(oi), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
